sofa_plus_scan_ctrl: RTL

- Scan-chain controller that sits directly upstream of a chain of sofa_plus_dff flops.
- Drives the chain's shared Test_en, the first flop's DI, and a clock-enable for the chain's clock gate.
- Samples the last flop's Q as scan-out.
- Serializes word-wide test patterns from a valid/ready stream into the chain, runs functional capture cycles, and repacks the unloaded bits into an output word stream.

---
 rtl/sofa_plus_scan_ctrl_if.sv | 19 +
 rtl/sofa_plus_scan_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sofa_plus_scan_ctrl_if.sv
// Pattern-in / response-out word streams between a test source and sofa_plus_scan_ctrl.
// The controller connects to the slave modport and the pattern/response side to the master modport.
interface sofa_plus_scan_ctrl_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   modport master (output in_data, in_last, in_valid, out_ready,
                   input  in_ready, out_data, out_last, out_valid);
   modport slave  (input  in_data, in_last, in_valid, out_ready,
                   output in_ready, out_data, out_last, out_valid);
endinterface

// File: rtl/sofa_plus_scan_ctrl.sv
// Scan-chain controller: serializes pattern words into a sofa_plus_dff chain, captures, repacks unload.
// Define SOFA_PLUS_SCAN_SIG_EN to build the 16-bit LFSR response signature on sig.
module sofa_plus_scan_ctrl #(
   parameter int CHAIN_LEN   = 64,
   parameter int DATA_W      = 8,
   parameter int CAPTURE_CYC = 1
) (
   input  logic                 C,
   input  logic                 R,
   input  logic                 start,
   sofa_plus_scan_ctrl_if.slave s,
   input  logic                 scan_out,
   output logic                 DI,
   output logic                 Test_en,
   output logic                 chain_clk_en,
   output logic                 busy,
   output logic [15:0]          sig
);
   localparam int WPP       = (CHAIN_LEN + DATA_W - 1) / DATA_W;
   localparam int LAST_BITS = CHAIN_LEN - (WPP - 1) * DATA_W;
   localparam int CW        = $clog2(CHAIN_LEN);
   localparam int BW        = $clog2(DATA_W + 1);
   localparam int WW        = $clog2(WPP + 1);
   localparam int KW        = $clog2(CAPTURE_CYC + 1);

   typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, FLUSH, DONE} state_e;

   state_e            state_q, state_d;
   logic [CW-1:0]     shift_cnt_q, shift_cnt_d;
   logic [KW-1:0]     cap_cnt_q, cap_cnt_d;
   logic [DATA_W-1:0] in_buf_q, in_buf_d;
   logic [BW-1:0]     in_cnt_q, in_cnt_d;
   logic [WW-1:0]     in_word_q, in_word_d;
   logic              pat_last_q, pat_last_d;
   logic [DATA_W-1:0] out_buf_q, out_buf_d;
   logic [BW-1:0]     out_idx_q, out_idx_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              beat, in_ready_c, out_room, last_bit;
   logic [DATA_W-1:0] obuf;
`ifdef SOFA_PLUS_SCAN_SIG_EN
   logic [15:0]       sig_q, sig_d;
`endif

   always_comb begin
      state_d      = state_q;
      shift_cnt_d  = shift_cnt_q;
      cap_cnt_d    = cap_cnt_q;
      in_buf_d     = in_buf_q;
      in_cnt_d     = in_cnt_q;
      in_word_d    = in_word_q;
      pat_last_d   = pat_last_q;
      out_buf_d    = out_buf_q;
      out_idx_d    = out_idx_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      beat         = 1'b0;
      in_ready_c   = 1'b0;
      DI           = 1'b0;
      Test_en      = 1'b0;
      chain_clk_en = 1'b0;
      obuf         = '0;
`ifdef SOFA_PLUS_SCAN_SIG_EN
      sig_d        = sig_q;
`endif
      // a full output register frees up in the same cycle it is handed off
      out_room = ~out_valid_q | s.out_ready;
      last_bit = (shift_cnt_q == CW'(CHAIN_LEN - 1));
      if (out_valid_q && s.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = SHIFT;
               shift_cnt_d = '0;
               in_cnt_d    = '0;
               in_word_d   = '0;
               out_idx_d   = '0;
`ifdef SOFA_PLUS_SCAN_SIG_EN
               sig_d       = '0;
`endif
            end
         end
         SHIFT: begin
            Test_en    = 1'b1;
            beat       = (in_cnt_q != '0) && out_room;
            DI         = beat & in_buf_q[0];
            in_ready_c = (in_word_q != WW'(WPP)) &&
                         ((in_cnt_q == '0) || (beat && in_cnt_q == BW'(1)));
            if (beat) begin
               in_buf_d = in_buf_q >> 1;
               in_cnt_d = in_cnt_q - BW'(1);
            end
            if (in_ready_c && s.in_valid) begin
               in_buf_d  = s.in_data;
               in_word_d = in_word_q + WW'(1);
               if (in_word_q == WW'(WPP - 1)) begin
                  in_cnt_d   = BW'(LAST_BITS);
                  pat_last_d = s.in_last;
               end else begin
                  in_cnt_d   = BW'(DATA_W);
               end
            end
         end
         CAPTURE: begin
            chain_clk_en = 1'b1;
            cap_cnt_d    = cap_cnt_q + KW'(1);
            if (cap_cnt_q == KW'(CAPTURE_CYC - 1)) begin
               cap_cnt_d = '0;
               in_word_d = '0;
               state_d   = pat_last_q ? FLUSH : SHIFT;
            end
         end
         FLUSH: begin
            Test_en = 1'b1;
            beat    = out_room;
         end
         DONE: begin
            if (out_valid_q && s.out_ready && out_last_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // each beat moves one bit into the chain and one bit out into the response word
      if (beat) begin
         chain_clk_en = 1'b1;
         obuf         = (out_idx_q == '0) ? '0 : out_buf_q;
         out_buf_d    = obuf | (DATA_W'(scan_out) << out_idx_q);
         if (out_idx_q == BW'(DATA_W - 1) || last_bit) begin
            out_valid_d = 1'b1;
            out_last_d  = (state_q == FLUSH) && last_bit;
            out_idx_d   = '0;
         end else begin
            out_idx_d   = out_idx_q + BW'(1);
         end
         shift_cnt_d = last_bit ? '0 : shift_cnt_q + CW'(1);
         if (last_bit) state_d = (state_q == SHIFT) ? CAPTURE : DONE;
`ifdef SOFA_PLUS_SCAN_SIG_EN
         sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ scan_out) ? 16'h1021 : 16'h0000);
`endif
      end
   end

   always_ff @(posedge C) begin
      if (R) begin
         state_q     <= IDLE;
         shift_cnt_q <= '0;
         cap_cnt_q   <= '0;
         in_buf_q    <= '0;
         in_cnt_q    <= '0;
         in_word_q   <= '0;
         pat_last_q  <= 1'b0;
         out_buf_q   <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
`ifdef SOFA_PLUS_SCAN_SIG_EN
         sig_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         shift_cnt_q <= shift_cnt_d;
         cap_cnt_q   <= cap_cnt_d;
         in_buf_q    <= in_buf_d;
         in_cnt_q    <= in_cnt_d;
         in_word_q   <= in_word_d;
         pat_last_q  <= pat_last_d;
         out_buf_q   <= out_buf_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
`ifdef SOFA_PLUS_SCAN_SIG_EN
         sig_q       <= sig_d;
`endif
      end
   end

`ifdef SOFA_PLUS_SCAN_SIG_EN
   assign sig = sig_q;
`else
   assign sig = 16'h0000;
`endif
   assign busy        = (state_q != IDLE);
   assign s.in_ready  = in_ready_c;
   assign s.out_data  = out_buf_q;
   assign s.out_valid = out_valid_q;
   assign s.out_last  = out_last_q;
endmodule
